// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IF/MEM pipeline stages, the arbiter and the shared bus.
// slave is the arbiter's view; master is the surrounding core/bus view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        stall_from_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        stall_from_mem;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_ack, bus_rdata,
    output if_rdata, stall_from_if, mem_rdata, stall_from_mem,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_ack, bus_rdata,
    input  if_rdata, stall_from_if, mem_rdata, stall_from_mem,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the IF and MEM stages, MEM first,
// with an optional one-entry fetch buffer that lets a reissued fetch skip the bus.
module mem_arbiter #(
  parameter bit FETCH_BUF_EN = 1'b1
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  mem_arbiter_if.slave  port
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IF_BUSY  = 3'd1,
    MEM_BUSY = 3'd2,
    IF_DONE  = 3'd3,
    MEM_DONE = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_s;
  logic        bus_req_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [31:0] bus_wdata_r;
  logic [3:0]  bus_be_r;
  logic [31:0] if_rdata_r;
  logic [31:0] mem_rdata_r;
  logic        buf_valid_r;
  logic [31:0] buf_addr_r;
  logic [31:0] buf_data_r;
  logic        hit_s;

  assign hit_s = FETCH_BUF_EN && buf_valid_r && (port.if_addr == buf_addr_r);

  assign port.bus_req        = bus_req_r;
  assign port.bus_we         = bus_we_r;
  assign port.bus_addr       = bus_addr_r;
  assign port.bus_wdata      = bus_wdata_r;
  assign port.bus_be         = bus_be_r;
  assign port.if_rdata       = if_rdata_r;
  assign port.mem_rdata      = mem_rdata_r;
  assign port.stall_from_if  = port.if_req  & (state_r != IF_DONE);
  assign port.stall_from_mem = port.mem_req & (state_r != MEM_DONE);

  // Next-state decode: MEM wins in IDLE, BUSY waits for ack, DONE lasts one cycle.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (port.mem_req) begin
          next_s = MEM_BUSY;
        end else if (port.if_req && hit_s) begin
          next_s = IF_DONE;
        end else if (port.if_req) begin
          next_s = IF_BUSY;
        end else begin
          next_s = IDLE;
        end
      end
      IF_BUSY: begin
        if (port.bus_ack) begin
          next_s = IF_DONE;
        end else begin
          next_s = IF_BUSY;
        end
      end
      MEM_BUSY: begin
        if (port.bus_ack) begin
          next_s = MEM_DONE;
        end else begin
          next_s = MEM_BUSY;
        end
      end
      IF_DONE:  next_s = IDLE;
      MEM_DONE: next_s = IDLE;
      default:  next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Bus launch, read-data capture and fetch-buffer maintenance.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_wdata_r <= 32'h0000_0000;
      bus_be_r    <= 4'h0;
      if_rdata_r  <= 32'h0000_0000;
      mem_rdata_r <= 32'h0000_0000;
      buf_valid_r <= 1'b0;
      buf_addr_r  <= 32'h0000_0000;
      buf_data_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (port.mem_req) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= port.mem_we;
            bus_addr_r  <= port.mem_addr;
            bus_wdata_r <= port.mem_wdata;
            bus_be_r    <= port.mem_be;
          end else if (port.if_req && hit_s) begin
            if_rdata_r <= buf_data_r;
          end else if (port.if_req) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= port.if_addr;
            bus_wdata_r <= 32'h0000_0000;
            bus_be_r    <= 4'hF;
          end
        end
        IF_BUSY: begin
          if (port.bus_ack) begin
            bus_req_r   <= 1'b0;
            if_rdata_r  <= port.bus_rdata;
            buf_valid_r <= FETCH_BUF_EN;
            buf_addr_r  <= bus_addr_r;
            buf_data_r  <= port.bus_rdata;
          end
        end
        MEM_BUSY: begin
          if (port.bus_ack) begin
            bus_req_r <= 1'b0;
            if (bus_we_r) begin
              // A write anywhere in the buffered word makes its copy stale.
              if (bus_addr_r[31:2] == buf_addr_r[31:2]) begin
                buf_valid_r <= 1'b0;
              end
            end else begin
              mem_rdata_r <= port.bus_rdata;
            end
          end
        end
        IF_DONE: begin
          // The fetch counts as consumed only when MEM is not stalling the pipe.
          if (!port.stall_from_mem) begin
            buf_valid_r <= 1'b0;
          end
        end
        MEM_DONE: begin
          bus_req_r <= 1'b0;
        end
        default: begin
          bus_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a bus responder plus per-port queues of expected read data.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];

  mem_arbiter_if bus_if ();

  mem_arbiter #(.FETCH_BUF_EN(1'b1)) dut (
    .cpu_clk (clk),
    .cpu_rst (rst),
    .port    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Wait for a launch, check the held bus fields, ack on the n-th BUSY cycle.
  task automatic serve(input string tag, input bit is_if, input int n_ack,
                       input logic [31:0] rdata, input logic [31:0] e_addr,
                       input logic e_we, input logic [31:0] e_wdata, input logic [3:0] e_be);
    int guard;
    guard = 0;
    while (bus_if.bus_req !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_launch"}, {31'd0, bus_if.bus_req}, 32'd1);
    for (int i = 1; i <= n_ack; i++) begin
      chk({tag, "_req"},   {31'd0, bus_if.bus_req}, 32'd1);
      chk({tag, "_addr"},  bus_if.bus_addr, e_addr);
      chk({tag, "_we"},    {31'd0, bus_if.bus_we}, {31'd0, e_we});
      chk({tag, "_wdata"}, bus_if.bus_wdata, e_wdata);
      chk({tag, "_be"},    {28'd0, bus_if.bus_be}, {28'd0, e_be});
      chk({tag, "_stall"}, {31'd0, (is_if ? bus_if.stall_from_if : bus_if.stall_from_mem)}, 32'd1);
      if (i == n_ack) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
      end
      tick();
    end
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0000_0000;
    chk({tag, "_req_clr"}, {31'd0, bus_if.bus_req}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = 32'h0;
    bus_if.mem_req   = 1'b0;
    bus_if.mem_we    = 1'b0;
    bus_if.mem_addr  = 32'h0;
    bus_if.mem_wdata = 32'h0;
    bus_if.mem_be    = 4'h0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Reset values, stall follows request while in reset.
    tick();
    tick();
    chk("rst_bus_req",   {31'd0, bus_if.bus_req}, 32'd0);
    chk("rst_bus_addr",  bus_if.bus_addr, 32'h0);
    chk("rst_bus_be",    {28'd0, bus_if.bus_be}, 32'd0);
    chk("rst_if_rdata",  bus_if.if_rdata, 32'h0);
    chk("rst_mem_rdata", bus_if.mem_rdata, 32'h0);
    bus_if.if_req = 1'b1;
    #1;
    chk("rst_stall_if", {31'd0, bus_if.stall_from_if}, 32'd1);
    bus_if.if_req = 1'b0;
    rst = 1'b0;
    tick();

    // Plain fetch, ack on the second BUSY cycle.
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 32'h0000_0100;
    if_q.push_back(32'h2408_0005);
    serve("fetch100", 1'b1, 2, 32'h2408_0005, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
    chk("fetch100_stall_rel", {31'd0, bus_if.stall_from_if}, 32'd0);
    chk("fetch100_rdata", bus_if.if_rdata, if_q.pop_front());
    bus_if.if_req = 1'b0;
    tick();

    // Collision: MEM read served first, then IF.
    bus_if.mem_req  = 1'b1;
    bus_if.mem_we   = 1'b0;
    bus_if.mem_addr = 32'h0000_0200;
    bus_if.mem_be   = 4'hF;
    bus_if.if_req   = 1'b1;
    bus_if.if_addr  = 32'h0000_0104;
    mem_q.push_back(32'h1111_2222);
    serve("coll_mem", 1'b0, 1, 32'h1111_2222, 32'h0000_0200, 1'b0, 32'h0, 4'hF);
    chk("coll_mem_stall_rel", {31'd0, bus_if.stall_from_mem}, 32'd0);
    chk("coll_if_stalled", {31'd0, bus_if.stall_from_if}, 32'd1);
    chk("coll_mem_rdata", bus_if.mem_rdata, mem_q.pop_front());
    bus_if.mem_req = 1'b0;
    tick();
    chk("coll_idle_noreq", {31'd0, bus_if.bus_req}, 32'd0);
    if_q.push_back(32'hAAAA_0104);
    serve("coll_if", 1'b1, 1, 32'hAAAA_0104, 32'h0000_0104, 1'b0, 32'h0, 4'hF);
    chk("coll_if_stall_rel", {31'd0, bus_if.stall_from_if}, 32'd0);
    chk("coll_if_rdata", bus_if.if_rdata, if_q.pop_front());

    // MEM request in IF_DONE keeps the buffer; the reissued fetch must hit.
    bus_if.mem_req  = 1'b1;
    bus_if.mem_addr = 32'h0000_0204;
    #1;
    chk("hit_mem_stall", {31'd0, bus_if.stall_from_mem}, 32'd1);
    tick();
    mem_q.push_back(32'h3333_4444);
    serve("hit_mem", 1'b0, 1, 32'h3333_4444, 32'h0000_0204, 1'b0, 32'h0, 4'hF);
    chk("hit_mem_rdata", bus_if.mem_rdata, mem_q.pop_front());
    bus_if.mem_req = 1'b0;
    tick();
    chk("hit_idle_noreq", {31'd0, bus_if.bus_req}, 32'd0);
    chk("hit_idle_stall", {31'd0, bus_if.stall_from_if}, 32'd1);
    if_q.push_back(32'hAAAA_0104);
    tick();
    chk("hit_done_noreq", {31'd0, bus_if.bus_req}, 32'd0);
    chk("hit_stall_rel", {31'd0, bus_if.stall_from_if}, 32'd0);
    chk("hit_rdata", bus_if.if_rdata, if_q.pop_front());

    // Partial write into the buffered word invalidates it: refetch goes to the bus.
    bus_if.mem_req   = 1'b1;
    bus_if.mem_we    = 1'b1;
    bus_if.mem_addr  = 32'h0000_0106;
    bus_if.mem_wdata = 32'h5555_AAAA;
    bus_if.mem_be    = 4'h3;
    tick();
    mem_q.push_back(32'h3333_4444);
    serve("inv_wr", 1'b0, 1, 32'hBAD0_BAD0, 32'h0000_0106, 1'b1, 32'h5555_AAAA, 4'h3);
    chk("inv_wr_rdata", bus_if.mem_rdata, mem_q.pop_front());
    bus_if.mem_req = 1'b0;
    bus_if.mem_we  = 1'b0;
    tick();
    if_q.push_back(32'h7777_0104);
    serve("inv_refetch", 1'b1, 1, 32'h7777_0104, 32'h0000_0104, 1'b0, 32'h0, 4'hF);
    chk("inv_refetch_rdata", bus_if.if_rdata, if_q.pop_front());
    bus_if.if_req = 1'b0;
    tick();

    // Write with slow ack; read data register must not move.
    bus_if.mem_req   = 1'b1;
    bus_if.mem_we    = 1'b1;
    bus_if.mem_addr  = 32'h0000_0300;
    bus_if.mem_wdata = 32'hDEAD_BEEF;
    bus_if.mem_be    = 4'hC;
    mem_q.push_back(32'h3333_4444);
    serve("wr300", 1'b0, 3, 32'hFEED_F00D, 32'h0000_0300, 1'b1, 32'hDEAD_BEEF, 4'hC);
    chk("wr300_stall_rel", {31'd0, bus_if.stall_from_mem}, 32'd0);
    chk("wr300_rdata", bus_if.mem_rdata, mem_q.pop_front());
    bus_if.mem_req = 1'b0;
    bus_if.mem_we  = 1'b0;
    tick();

    // Reset in the second MEM_BUSY cycle, late ack must be ignored.
    bus_if.mem_req  = 1'b1;
    bus_if.mem_addr = 32'h0000_0400;
    bus_if.mem_be   = 4'hF;
    tick();
    chk("rstmid_busy1", {31'd0, bus_if.bus_req}, 32'd1);
    tick();
    chk("rstmid_busy2", {31'd0, bus_if.bus_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rstmid_req", {31'd0, bus_if.bus_req}, 32'd0);
    chk("rstmid_mem_rdata", bus_if.mem_rdata, 32'h0);
    chk("rstmid_if_rdata", bus_if.if_rdata, 32'h0);
    chk("rstmid_stall", {31'd0, bus_if.stall_from_mem}, 32'd1);
    rst = 1'b0;
    bus_if.mem_req   = 1'b0;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h9999_9999;
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    chk("rstmid_late_rdata", bus_if.mem_rdata, 32'h0);
    chk("rstmid_late_req", {31'd0, bus_if.bus_req}, 32'd0);
    bus_if.mem_req = 1'b1;
    #1;
    chk("rstmid_not_done", {31'd0, bus_if.stall_from_mem}, 32'd1);
    bus_if.mem_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
